// File: rtl/semaphore_pkg.sv
// Shared types, constants and helpers for the traffic-light sequencer.
// Lamp encoding and phase decoding live here so the top and the bench agree.
`ifndef SEMAPHORE_WIRE_W
`define SEMAPHORE_WIRE_W
`define WIRE_W(N) logic [(N)-1:0]
`endif

package semaphore_pkg;

    typedef logic [3:0] u4_t;
    typedef logic [7:0] u8_t;

    typedef enum logic [3:0] {
        GREEN  = 4'd0,
        YELLOW = 4'd1,
        RED    = 4'd2
    } addr_e;

    localparam int NMB_SIG_SEMAPHORE = 3;

    localparam int SIG_RED    = 0;
    localparam int SIG_YELLOW = 1;
    localparam int SIG_GREEN  = 2;

    typedef enum logic [2:0] {
        ST_RED         = 3'd0,
        ST_RED_YELLOW  = 3'd1,
        ST_GREEN       = 3'd2,
        ST_GREEN_BLINK = 3'd3,
        ST_YELLOW      = 3'd4
    } phase_e;

    // A programmed duration of zero still occupies one tick.
    function automatic u8_t eff_dur(input u8_t d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    function automatic logic [NMB_SIG_SEMAPHORE-1:0] lamps(input phase_e ph, input logic blink_off);
        logic [NMB_SIG_SEMAPHORE-1:0] l;
        l = '0;
        case (ph)
            ST_RED: begin
                l[SIG_RED] = 1'b1;
            end
            ST_RED_YELLOW: begin
                l[SIG_RED]    = 1'b1;
                l[SIG_YELLOW] = 1'b1;
            end
            ST_GREEN: begin
                l[SIG_GREEN] = 1'b1;
            end
            ST_GREEN_BLINK: begin
                l[SIG_GREEN] = ~blink_off;
            end
            ST_YELLOW: begin
                l[SIG_YELLOW] = 1'b1;
            end
            default: begin
                l[SIG_RED] = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaphore_tick_gen.sv
// Duration-tick prescaler: pulses once every TICK_DIV clocks, restartable
// with a synchronous clear so each phase starts on a fresh tick boundary.
module semaphore_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Prescaler count, wraps at LAST and restarts on clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/semaphore_task_3.sv
// Traffic-light sequencer: RED -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW,
// with host-programmable red/yellow/green durations counted in prescaled ticks.
module semaphore_task_3
    import semaphore_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int BLINK_TICKS = 4,
    parameter int RST_RED     = 10,
    parameter int RST_YELLOW  = 3,
    parameter int RST_GREEN   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  u4_t                           Addr,
    input  logic                          write,
    input  u8_t                           Data,
    output `WIRE_W(NMB_SIG_SEMAPHORE)     sm_sig
);

    u8_t    dur_red_r;
    u8_t    dur_yellow_r;
    u8_t    dur_green_r;

    phase_e state_r;
    phase_e state_nxt_s;
    u8_t    remain_r;
    u8_t    remain_nxt_s;
    logic   blink_odd_r;
    logic   blink_odd_nxt_s;
    logic   advance_s;
    logic   tick_s;
    logic [NMB_SIG_SEMAPHORE-1:0] sig_nxt_s;

    semaphore_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (advance_s),
        .tick  (tick_s)
    );

    // Duration registers; unmapped addresses fall through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            dur_red_r    <= u8_t'(RST_RED);
            dur_yellow_r <= u8_t'(RST_YELLOW);
            dur_green_r  <= u8_t'(RST_GREEN);
        end else if (write) begin
            case (Addr)
                u4_t'(GREEN):  dur_green_r  <= Data;
                u4_t'(YELLOW): dur_yellow_r <= Data;
                u4_t'(RED):    dur_red_r    <= Data;
                default: begin
                end
            endcase
        end else begin
            dur_red_r    <= dur_red_r;
            dur_yellow_r <= dur_yellow_r;
            dur_green_r  <= dur_green_r;
        end
    end

    // Phase advance and reload; the reload reads the pre-write register value.
    always_comb begin
        state_nxt_s     = state_r;
        remain_nxt_s    = remain_r;
        blink_odd_nxt_s = blink_odd_r;
        advance_s       = 1'b0;
        if (tick_s) begin
            if (remain_r <= 8'd1) begin
                advance_s       = 1'b1;
                blink_odd_nxt_s = 1'b0;
                case (state_r)
                    ST_RED: begin
                        state_nxt_s  = ST_RED_YELLOW;
                        remain_nxt_s = eff_dur(dur_yellow_r);
                    end
                    ST_RED_YELLOW: begin
                        state_nxt_s  = ST_GREEN;
                        remain_nxt_s = eff_dur(dur_green_r);
                    end
                    ST_GREEN: begin
                        state_nxt_s  = ST_GREEN_BLINK;
                        remain_nxt_s = eff_dur(u8_t'(BLINK_TICKS));
                    end
                    ST_GREEN_BLINK: begin
                        state_nxt_s  = ST_YELLOW;
                        remain_nxt_s = eff_dur(dur_yellow_r);
                    end
                    ST_YELLOW: begin
                        state_nxt_s  = ST_RED;
                        remain_nxt_s = eff_dur(dur_red_r);
                    end
                    default: begin
                        state_nxt_s  = ST_RED;
                        remain_nxt_s = eff_dur(dur_red_r);
                    end
                endcase
            end else begin
                remain_nxt_s    = remain_r - 8'd1;
                blink_odd_nxt_s = ~blink_odd_r;
            end
        end else begin
            remain_nxt_s = remain_r;
        end
        sig_nxt_s = lamps(state_nxt_s, blink_odd_nxt_s);
    end

    // Phase state and lamp register; lamps are decoded from the next state so
    // sm_sig changes on the same edge as the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RED;
            remain_r    <= u8_t'(RST_RED);
            blink_odd_r <= 1'b0;
            sm_sig      <= lamps(ST_RED, 1'b0);
        end else begin
            state_r     <= state_nxt_s;
            remain_r    <= remain_nxt_s;
            blink_odd_r <= blink_odd_nxt_s;
            sm_sig      <= sig_nxt_s;
        end
    end

endmodule

// File: tb/tb_semaphore_task_3.sv
// Directed bench for the traffic-light sequencer: phase lengths, programming,
// write/load collision, mid-sequence reset and a prescaled instance.
module tb_semaphore_task_3;
    import semaphore_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    u4_t        Addr;
    u8_t        Data;
    logic [2:0] sm_sig;

    logic       reset4;
    logic       write4;
    u4_t        addr4;
    u8_t        data4;
    logic [2:0] sm_sig4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    semaphore_task_3 #(.TICK_DIV(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .write  (write),
        .Data   (Data),
        .sm_sig (sm_sig)
    );

    semaphore_task_3 #(.TICK_DIV(4)) dut4 (
        .clk    (clk),
        .reset  (reset4),
        .Addr   (addr4),
        .write  (write4),
        .Data   (data4),
        .sm_sig (sm_sig4)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_chk++;
        if (obs === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at t=%0t", tag, obs[2:0], want[2:0], $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle: apply write inputs, check the current lamps, advance a clock.
    task automatic cyc(input string tag, input logic [2:0] want, input logic wr,
                       input u4_t a, input u8_t d, input bit use4);
        write = wr;
        Addr  = a;
        Data  = d;
        check_val(tag, use4 ? {5'd0, sm_sig4} : {5'd0, sm_sig}, {5'd0, want});
        step();
        write = 1'b0;
    endtask

    task automatic phase(input string tag, input logic [2:0] want, input int n, input bit use4);
        for (int i = 0; i < n; i++) begin
            cyc(tag, want, 1'b0, 4'd0, 8'd0, use4);
        end
    endtask

    // Everything after RED: RED_YELLOW, GREEN, four blink ticks, YELLOW.
    task automatic rest(input int ry, input int g, input int y, input int k, input bit use4);
        phase("red_yellow", 3'b011, ry, use4);
        phase("green", 3'b100, g, use4);
        phase("blink_on0", 3'b100, k, use4);
        phase("blink_off1", 3'b000, k, use4);
        phase("blink_on2", 3'b100, k, use4);
        phase("blink_off3", 3'b000, k, use4);
        phase("yellow", 3'b010, y, use4);
    endtask

    u4_t addr_tab [3] = '{GREEN, YELLOW, RED};
    u8_t data_tab [3] = '{8'd20, 8'd30, 8'd40};

    initial begin
        reset  = 1'b1;
        write  = 1'b0;
        Addr   = 4'd0;
        Data   = 8'd0;
        reset4 = 1'b1;
        write4 = 1'b0;
        addr4  = 4'd0;
        data4  = 8'd0;
        step();

        // Reset holds RED and ignores a write of RED=2.
        for (int i = 0; i < 3; i++) begin
            cyc("reset_red", 3'b001, 1'b1, RED, 8'd2, 1'b0);
        end
        check_val("reset_red4", {5'd0, sm_sig4}, 8'd1);

        // Defaults: period of 28 cycles starting at cycle 0.
        reset = 1'b0;
        phase("red_default", 3'b001, 10, 1'b0);
        rest(3, 8, 3, 1, 1'b0);

        // Program on alternate cycles inside RED; the running RED keeps 10.
        for (int i = 0; i < 10; i++) begin
            cyc("red_during_writes", 3'b001, (i < 6) && (i % 2 == 0),
                addr_tab[i / 2 % 3], data_tab[i / 2 % 3], 1'b0);
        end
        rest(30, 20, 30, 1, 1'b0);

        // RED=0 plus writes to unmapped addresses during the 40-cycle RED.
        cyc("red40", 3'b001, 1'b1, RED, 8'd0, 1'b0);
        cyc("red40", 3'b001, 1'b1, 4'd7, 8'd99, 1'b0);
        cyc("red40", 3'b001, 1'b1, 4'd4, 8'd99, 1'b0);
        cyc("red40", 3'b001, 1'b1, 4'd15, 8'd99, 1'b0);
        phase("red40", 3'b001, 36, 1'b0);
        rest(30, 20, 30, 1, 1'b0);

        // One-cycle RED; a yellow write there collides with the RED_YELLOW load.
        cyc("red_zero", 3'b001, 1'b1, YELLOW, 8'd5, 1'b0);
        rest(30, 20, 5, 1, 1'b0);
        phase("red_zero2", 3'b001, 1, 1'b0);
        phase("red_yellow_new", 3'b011, 5, 1'b0);
        phase("green_pre_reset", 3'b100, 10, 1'b0);

        // Single-cycle reset in the middle of GREEN restores defaults.
        reset = 1'b1;
        cyc("green_at_reset", 3'b100, 1'b0, 4'd0, 8'd0, 1'b0);
        reset = 1'b0;
        phase("red_after_reset", 3'b001, 10, 1'b0);
        rest(3, 8, 3, 1, 1'b0);
        phase("red_wrap", 3'b001, 1, 1'b0);

        // Prescaled instance, TICK_DIV=4.
        reset4 = 1'b0;
        phase("red_div4", 3'b001, 40, 1'b1);
        rest(12, 32, 12, 4, 1'b1);
        phase("red_div4_wrap", 3'b001, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
